// File: rtl/axi_cdc_intf.sv
// AXI register-slice style decoupler: each of the five channels is an independent
// 2-entry FIFO with registered ready, one-cycle latency and full throughput.
module axi_cdc_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready
);
  logic [DATA_W-1:0] r_mem [2];
  logic [1:0]        r_wptr, r_rptr;
  logic              r_ready;
  logic              w_empty, w_push, w_pop, w_full_nxt;
  logic [1:0]        w_wptr_nxt, w_rptr_nxt;

  assign w_empty    = (r_wptr == r_rptr);
  assign w_push     = i_valid && r_ready;
  assign w_pop      = !w_empty && i_ready;
  assign w_wptr_nxt = r_wptr + {1'b0, w_push};
  assign w_rptr_nxt = r_rptr + {1'b0, w_pop};
  // Full when index bits match but wrap bits differ; ready is registered from this.
  assign w_full_nxt = (w_wptr_nxt[0] == w_rptr_nxt[0]) && (w_wptr_nxt[1] != w_rptr_nxt[1]);

  assign o_ready = r_ready;
  assign o_valid = !w_empty;
  assign o_data  = r_mem[r_rptr[0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_ready  <= 1'b0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_ready <= !w_full_nxt;
      if (w_push) r_mem[r_wptr[0]] <= i_data;
    end
  end
endmodule

module axi_cdc_intf #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_USER_WIDTH = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  // slave AW
  input  logic [AXI_ID_WIDTH-1:0]     s_aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_aw_addr,
  input  logic [7:0]                  s_aw_len,
  input  logic [2:0]                  s_aw_size,
  input  logic [1:0]                  s_aw_burst,
  input  logic                        s_aw_lock,
  input  logic [3:0]                  s_aw_cache,
  input  logic [2:0]                  s_aw_prot,
  input  logic [3:0]                  s_aw_qos,
  input  logic [3:0]                  s_aw_region,
  input  logic [5:0]                  s_aw_atop,
  input  logic [AXI_USER_WIDTH-1:0]   s_aw_user,
  input  logic                        s_aw_valid,
  output logic                        s_aw_ready,
  // slave W
  input  logic [AXI_DATA_WIDTH-1:0]   s_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_w_strb,
  input  logic                        s_w_last,
  input  logic [AXI_USER_WIDTH-1:0]   s_w_user,
  input  logic                        s_w_valid,
  output logic                        s_w_ready,
  // slave B
  output logic [AXI_ID_WIDTH-1:0]     s_b_id,
  output logic [1:0]                  s_b_resp,
  output logic [AXI_USER_WIDTH-1:0]   s_b_user,
  output logic                        s_b_valid,
  input  logic                        s_b_ready,
  // slave AR
  input  logic [AXI_ID_WIDTH-1:0]     s_ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_ar_addr,
  input  logic [7:0]                  s_ar_len,
  input  logic [2:0]                  s_ar_size,
  input  logic [1:0]                  s_ar_burst,
  input  logic                        s_ar_lock,
  input  logic [3:0]                  s_ar_cache,
  input  logic [2:0]                  s_ar_prot,
  input  logic [3:0]                  s_ar_qos,
  input  logic [3:0]                  s_ar_region,
  input  logic [AXI_USER_WIDTH-1:0]   s_ar_user,
  input  logic                        s_ar_valid,
  output logic                        s_ar_ready,
  // slave R
  output logic [AXI_ID_WIDTH-1:0]     s_r_id,
  output logic [AXI_DATA_WIDTH-1:0]   s_r_data,
  output logic [1:0]                  s_r_resp,
  output logic                        s_r_last,
  output logic [AXI_USER_WIDTH-1:0]   s_r_user,
  output logic                        s_r_valid,
  input  logic                        s_r_ready,
  // master AW
  output logic [AXI_ID_WIDTH-1:0]     m_aw_id,
  output logic [AXI_ADDR_WIDTH-1:0]   m_aw_addr,
  output logic [7:0]                  m_aw_len,
  output logic [2:0]                  m_aw_size,
  output logic [1:0]                  m_aw_burst,
  output logic                        m_aw_lock,
  output logic [3:0]                  m_aw_cache,
  output logic [2:0]                  m_aw_prot,
  output logic [3:0]                  m_aw_qos,
  output logic [3:0]                  m_aw_region,
  output logic [5:0]                  m_aw_atop,
  output logic [AXI_USER_WIDTH-1:0]   m_aw_user,
  output logic                        m_aw_valid,
  input  logic                        m_aw_ready,
  // master W
  output logic [AXI_DATA_WIDTH-1:0]   m_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] m_w_strb,
  output logic                        m_w_last,
  output logic [AXI_USER_WIDTH-1:0]   m_w_user,
  output logic                        m_w_valid,
  input  logic                        m_w_ready,
  // master B
  input  logic [AXI_ID_WIDTH-1:0]     m_b_id,
  input  logic [1:0]                  m_b_resp,
  input  logic [AXI_USER_WIDTH-1:0]   m_b_user,
  input  logic                        m_b_valid,
  output logic                        m_b_ready,
  // master AR
  output logic [AXI_ID_WIDTH-1:0]     m_ar_id,
  output logic [AXI_ADDR_WIDTH-1:0]   m_ar_addr,
  output logic [7:0]                  m_ar_len,
  output logic [2:0]                  m_ar_size,
  output logic [1:0]                  m_ar_burst,
  output logic                        m_ar_lock,
  output logic [3:0]                  m_ar_cache,
  output logic [2:0]                  m_ar_prot,
  output logic [3:0]                  m_ar_qos,
  output logic [3:0]                  m_ar_region,
  output logic [AXI_USER_WIDTH-1:0]   m_ar_user,
  output logic                        m_ar_valid,
  input  logic                        m_ar_ready,
  // master R
  input  logic [AXI_ID_WIDTH-1:0]     m_r_id,
  input  logic [AXI_DATA_WIDTH-1:0]   m_r_data,
  input  logic [1:0]                  m_r_resp,
  input  logic                        m_r_last,
  input  logic [AXI_USER_WIDTH-1:0]   m_r_user,
  input  logic                        m_r_valid,
  output logic                        m_r_ready
);
  localparam int AR_W = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + AXI_USER_WIDTH;
  localparam int AW_W = AR_W + 6;
  localparam int W_W  = AXI_DATA_WIDTH + AXI_DATA_WIDTH/8 + 1 + AXI_USER_WIDTH;
  localparam int B_W  = AXI_ID_WIDTH + 2 + AXI_USER_WIDTH;
  localparam int R_W  = AXI_ID_WIDTH + AXI_DATA_WIDTH + 2 + 1 + AXI_USER_WIDTH;

  logic [AW_W-1:0] w_aw_in, w_aw_out;
  logic [W_W-1:0]  w_w_in,  w_w_out;
  logic [B_W-1:0]  w_b_in,  w_b_out;
  logic [AR_W-1:0] w_ar_in, w_ar_out;
  logic [R_W-1:0]  w_r_in,  w_r_out;

  assign w_aw_in = {s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_lock,
                    s_aw_cache, s_aw_prot, s_aw_qos, s_aw_region, s_aw_atop, s_aw_user};
  assign {m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_lock,
          m_aw_cache, m_aw_prot, m_aw_qos, m_aw_region, m_aw_atop, m_aw_user} = w_aw_out;

  assign w_w_in = {s_w_data, s_w_strb, s_w_last, s_w_user};
  assign {m_w_data, m_w_strb, m_w_last, m_w_user} = w_w_out;

  assign w_b_in = {m_b_id, m_b_resp, m_b_user};
  assign {s_b_id, s_b_resp, s_b_user} = w_b_out;

  assign w_ar_in = {s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_lock,
                    s_ar_cache, s_ar_prot, s_ar_qos, s_ar_region, s_ar_user};
  assign {m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_lock,
          m_ar_cache, m_ar_prot, m_ar_qos, m_ar_region, m_ar_user} = w_ar_out;

  assign w_r_in = {m_r_id, m_r_data, m_r_resp, m_r_last, m_r_user};
  assign {s_r_id, s_r_data, s_r_resp, s_r_last, s_r_user} = w_r_out;

  // Forward channels push from the slave side, backward channels from the master side.
  axi_cdc_fifo #(.DATA_W(AW_W)) u_aw (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_valid(s_aw_valid), .i_data(w_aw_in), .o_ready(s_aw_ready),
    .o_valid(m_aw_valid), .o_data(w_aw_out), .i_ready(m_aw_ready));
  axi_cdc_fifo #(.DATA_W(W_W)) u_w (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_valid(s_w_valid), .i_data(w_w_in), .o_ready(s_w_ready),
    .o_valid(m_w_valid), .o_data(w_w_out), .i_ready(m_w_ready));
  axi_cdc_fifo #(.DATA_W(B_W)) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_valid(m_b_valid), .i_data(w_b_in), .o_ready(m_b_ready),
    .o_valid(s_b_valid), .o_data(w_b_out), .i_ready(s_b_ready));
  axi_cdc_fifo #(.DATA_W(AR_W)) u_ar (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_valid(s_ar_valid), .i_data(w_ar_in), .o_ready(s_ar_ready),
    .o_valid(m_ar_valid), .o_data(w_ar_out), .i_ready(m_ar_ready));
  axi_cdc_fifo #(.DATA_W(R_W)) u_r (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_valid(m_r_valid), .i_data(w_r_in), .o_ready(m_r_ready),
    .o_valid(s_r_valid), .o_data(w_r_out), .i_ready(s_r_ready));
endmodule

// File: tb/tb_axi_cdc_intf.sv
// Directed self-checking bench for axi_cdc_intf, plus a scoreboarded random run on W.
module tb_axi_cdc_intf;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [5:0]  s_aw_id = '0;  logic [31:0] s_aw_addr = '0; logic [7:0] s_aw_len = '0;
  logic [2:0]  s_aw_size = '0; logic [1:0] s_aw_burst = '0; logic s_aw_lock = 1'b0;
  logic [3:0]  s_aw_cache = '0; logic [2:0] s_aw_prot = '0; logic [3:0] s_aw_qos = '0;
  logic [3:0]  s_aw_region = '0; logic [5:0] s_aw_atop = '0; logic [0:0] s_aw_user = '0;
  logic        s_aw_valid = 1'b0; logic s_aw_ready;
  logic [63:0] s_w_data = '0; logic [7:0] s_w_strb = '0; logic s_w_last = 1'b0;
  logic [0:0]  s_w_user = '0; logic s_w_valid = 1'b0; logic s_w_ready;
  logic [5:0]  s_b_id; logic [1:0] s_b_resp; logic [0:0] s_b_user; logic s_b_valid;
  logic        s_b_ready = 1'b0;
  logic [5:0]  s_ar_id = '0; logic [31:0] s_ar_addr = '0; logic [7:0] s_ar_len = '0;
  logic [2:0]  s_ar_size = '0; logic [1:0] s_ar_burst = '0; logic s_ar_lock = 1'b0;
  logic [3:0]  s_ar_cache = '0; logic [2:0] s_ar_prot = '0; logic [3:0] s_ar_qos = '0;
  logic [3:0]  s_ar_region = '0; logic [0:0] s_ar_user = '0;
  logic        s_ar_valid = 1'b0; logic s_ar_ready;
  logic [5:0]  s_r_id; logic [63:0] s_r_data; logic [1:0] s_r_resp; logic s_r_last;
  logic [0:0]  s_r_user; logic s_r_valid; logic s_r_ready = 1'b0;
  logic [5:0]  m_aw_id; logic [31:0] m_aw_addr; logic [7:0] m_aw_len; logic [2:0] m_aw_size;
  logic [1:0]  m_aw_burst; logic m_aw_lock; logic [3:0] m_aw_cache; logic [2:0] m_aw_prot;
  logic [3:0]  m_aw_qos; logic [3:0] m_aw_region; logic [5:0] m_aw_atop; logic [0:0] m_aw_user;
  logic        m_aw_valid; logic m_aw_ready = 1'b0;
  logic [63:0] m_w_data; logic [7:0] m_w_strb; logic m_w_last; logic [0:0] m_w_user;
  logic        m_w_valid; logic m_w_ready = 1'b0;
  logic [5:0]  m_b_id = '0; logic [1:0] m_b_resp = '0; logic [0:0] m_b_user = '0;
  logic        m_b_valid = 1'b0; logic m_b_ready;
  logic [5:0]  m_ar_id; logic [31:0] m_ar_addr; logic [7:0] m_ar_len; logic [2:0] m_ar_size;
  logic [1:0]  m_ar_burst; logic m_ar_lock; logic [3:0] m_ar_cache; logic [2:0] m_ar_prot;
  logic [3:0]  m_ar_qos; logic [3:0] m_ar_region; logic [0:0] m_ar_user;
  logic        m_ar_valid; logic m_ar_ready = 1'b0;
  logic [5:0]  m_r_id = '0; logic [63:0] m_r_data = '0; logic [1:0] m_r_resp = '0;
  logic        m_r_last = 1'b0; logic [0:0] m_r_user = '0; logic m_r_valid = 1'b0;
  logic        m_r_ready;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  axi_cdc_intf dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
    .s_aw_burst(s_aw_burst), .s_aw_lock(s_aw_lock), .s_aw_cache(s_aw_cache), .s_aw_prot(s_aw_prot),
    .s_aw_qos(s_aw_qos), .s_aw_region(s_aw_region), .s_aw_atop(s_aw_atop), .s_aw_user(s_aw_user),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last), .s_w_user(s_w_user),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .s_b_id(s_b_id), .s_b_resp(s_b_resp), .s_b_user(s_b_user), .s_b_valid(s_b_valid),
    .s_b_ready(s_b_ready),
    .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
    .s_ar_burst(s_ar_burst), .s_ar_lock(s_ar_lock), .s_ar_cache(s_ar_cache), .s_ar_prot(s_ar_prot),
    .s_ar_qos(s_ar_qos), .s_ar_region(s_ar_region), .s_ar_user(s_ar_user),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_id(s_r_id), .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .s_r_user(s_r_user), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
    .m_aw_burst(m_aw_burst), .m_aw_lock(m_aw_lock), .m_aw_cache(m_aw_cache), .m_aw_prot(m_aw_prot),
    .m_aw_qos(m_aw_qos), .m_aw_region(m_aw_region), .m_aw_atop(m_aw_atop), .m_aw_user(m_aw_user),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last), .m_w_user(m_w_user),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_b_id(m_b_id), .m_b_resp(m_b_resp), .m_b_user(m_b_user), .m_b_valid(m_b_valid),
    .m_b_ready(m_b_ready),
    .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
    .m_ar_burst(m_ar_burst), .m_ar_lock(m_ar_lock), .m_ar_cache(m_ar_cache), .m_ar_prot(m_ar_prot),
    .m_ar_qos(m_ar_qos), .m_ar_region(m_ar_region), .m_ar_user(m_ar_user),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .m_r_user(m_r_user), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [73:0] q[$];
  logic [73:0] w_word;
  logic        exp_push, exp_pop;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_rdy", {s_aw_ready, s_w_ready, s_ar_ready, m_b_ready, m_r_ready}, 5'b0);
    chk("rst_vld", {m_aw_valid, m_w_valid, m_ar_valid, s_b_valid, s_r_valid}, 5'b0);
    chk("rst_data", {m_aw_addr, m_w_data, s_r_data}, '0);
    #3 rst_ni = 1'b1;
    #1 chk("rdy_before_edge", s_aw_ready, 1'b0);
    tick();
    chk("rdy_after_rel", {s_aw_ready, s_w_ready, s_ar_ready, m_b_ready, m_r_ready}, 5'b11111);

    // Single AW beat
    s_aw_id = 6'h05; s_aw_addr = 32'h8000_0000; s_aw_len = 8'd0; s_aw_size = 3'd3;
    s_aw_burst = 2'd1; s_aw_cache = 4'hA; s_aw_atop = 6'h21; s_aw_user = 1'b1; s_aw_valid = 1'b1;
    tick();
    s_aw_valid = 1'b0;
    chk("aw_vld", m_aw_valid, 1'b1);
    chk("aw_fields", {m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_cache, m_aw_atop, m_aw_user},
        {6'h05, 32'h8000_0000, 8'd0, 3'd3, 2'd1, 4'hA, 6'h21, 1'b1});
    chk("aw_rdy", s_aw_ready, 1'b1);
    m_aw_ready = 1'b1;
    tick();
    chk("aw_pop", m_aw_valid, 1'b0);
    m_aw_ready = 1'b0;

    // W backpressure
    s_w_valid = 1'b1; s_w_data = 64'h1; s_w_strb = 8'hFF; s_w_last = 1'b0;
    tick();
    chk("w_rdy1", s_w_ready, 1'b1);
    s_w_data = 64'h2;
    tick();
    chk("w_rdy_full", s_w_ready, 1'b0);
    chk("w_head1", {m_w_valid, m_w_data, m_w_last}, {1'b1, 64'h1, 1'b0});
    s_w_data = 64'h3; s_w_last = 1'b1;
    tick();
    chk("w_rdy_hold", s_w_ready, 1'b0);
    chk("w_head_hold", m_w_data, 64'h1);
    m_w_ready = 1'b1;
    tick();
    chk("w_beat2", {m_w_valid, m_w_data, m_w_last}, {1'b1, 64'h2, 1'b0});
    chk("w_rdy_back", s_w_ready, 1'b1);
    tick();
    s_w_valid = 1'b0;
    chk("w_beat3", {m_w_valid, m_w_data, m_w_last}, {1'b1, 64'h3, 1'b1});
    tick();
    chk("w_empty", m_w_valid, 1'b0);
    m_w_ready = 1'b0; s_w_last = 1'b0;

    // R streaming, 16 beats back to back
    s_r_ready = 1'b1; m_r_valid = 1'b1; m_r_id = 6'h2A; m_r_resp = 2'd1;
    for (int i = 0; i < 16; i++) begin
      m_r_data = 64'h100 + 64'(i); m_r_last = (i == 15);
      tick();
      chk("r_stream", {s_r_valid, s_r_id, s_r_data, s_r_last, m_r_ready},
          {1'b1, 6'h2A, 64'h100 + 64'(i), (i == 15), 1'b1});
    end
    m_r_valid = 1'b0;
    tick();
    chk("r_drain", s_r_valid, 1'b0);
    s_r_ready = 1'b0;

    // AR stalled while B passes through
    s_ar_valid = 1'b1; s_ar_addr = 32'hA000_0000; s_ar_id = 6'h11;
    m_b_valid = 1'b1; m_b_resp = 2'd2; m_b_id = 6'h3F; s_b_ready = 1'b1;
    tick();
    m_b_valid = 1'b0; s_ar_addr = 32'hB000_0000;
    chk("b_deliv", {s_b_valid, s_b_resp, s_b_id}, {1'b1, 2'd2, 6'h3F});
    tick();
    s_ar_valid = 1'b0;
    chk("b_popped", s_b_valid, 1'b0);
    chk("ar_full", {s_ar_ready, m_ar_valid, m_ar_addr}, {1'b0, 1'b1, 32'hA000_0000});
    m_ar_ready = 1'b1;
    tick();
    chk("ar_beat2", {m_ar_valid, m_ar_addr, m_ar_id}, {1'b1, 32'hB000_0000, 6'h11});
    tick();
    chk("ar_empty", m_ar_valid, 1'b0);
    m_ar_ready = 1'b0; s_b_ready = 1'b0;

    // Async reset with AW full
    s_aw_valid = 1'b1; s_aw_addr = 32'h1234_5678;
    tick();
    s_aw_addr = 32'h9ABC_DEF0;
    tick();
    s_aw_valid = 1'b0;
    chk("aw_full", {s_aw_ready, m_aw_valid}, 2'b01);
    #2 rst_ni = 1'b0;
    #1 chk("arst_now", {m_aw_valid, s_aw_ready, m_aw_addr}, {1'b0, 1'b0, 32'h0});
    #1 rst_ni = 1'b1;
    tick();
    chk("arst_rel", {s_aw_ready, m_aw_valid}, 2'b10);
    m_aw_ready = 1'b1;
    tick();
    chk("arst_nostale", m_aw_valid, 1'b0);
    m_aw_ready = 1'b0;

    // Random valid/ready on W with an in-order scoreboard
    for (int c = 0; c < 400; c++) begin
      s_w_valid = 1'($urandom_range(0, 1)); m_w_ready = 1'($urandom_range(0, 1));
      s_w_data = {$urandom, $urandom}; s_w_strb = 8'($urandom);
      s_w_last = 1'($urandom); s_w_user = 1'($urandom);
      #1;
      chk("rnd_vld", m_w_valid, q.size() != 0);
      chk("rnd_rdy", s_w_ready, q.size() < 2);
      exp_pop  = (q.size() != 0) && m_w_ready;
      exp_push = s_w_valid && (q.size() < 2);
      if (exp_pop) chk("rnd_data", {m_w_data, m_w_strb, m_w_last, m_w_user}, q[0]);
      w_word = {s_w_data, s_w_strb, s_w_last, s_w_user};
      tick();
      if (exp_pop) void'(q.pop_front());
      if (exp_push) q.push_back(w_word);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
